alu32: RTL and testbench
========================

// Module: alu32
// PURPOSE
//  32-bit integer ALU with registered outputs: AND/OR/NOR/XOR, add, subtract, optional set-less-than.
//  Produces a result, an a<b compare flag and an arithmetic overflow flag, signed or unsigned per unsig.
//  Sits in the datapath execute stage; one clock, all outputs registered.
// PARAMETERS
//  WIDTH  32  operand/result width (all behaviour below stated for 32)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   reset, asynchronous, active-high
//  a         in   32  operand A
//  b         in   32  operand B
//  op        in   3   operation select
//  unsig     in   1   1 = signed arithmetic/compare, 0 = unsigned
//  aluout    out  32  registered result
//  compout   out  1   registered compare flag (a < b)
//  overflow  out  1   registered overflow flag
// BEHAVIOUR
//  - rst=1: aluout=0, compout=0, overflow=0 immediately (async), held until rst=0.
//  - Latency 1: inputs sampled at posedge clk; outputs updated at same edge and held until next edge.
//  - No handshake; new operation accepted every cycle.
//  - op decode:
//    000 aluout=a&b; 001 a|b; 010 a+b (mod 2^32); 100 ~(a|b); 101 a^b; 110 a-b (mod 2^32)
//    011 SLT (see CONFIGURATION); 111 aluout=0, overflow=0
//  - compout: every op, a<b; signed two's-complement compare if unsig=1, unsigned if unsig=0.
//  - overflow, unsig=1 (signed):
//    add: a[31]==b[31] && res[31]!=a[31]; sub: a[31]!=b[31] && res[31]!=a[31]
//  - overflow, unsig=0 (unsigned):
//    add: carry out of bit 31 (33-bit sum bit 32); sub: borrow (a<b unsigned)
//  - overflow=0 for logic ops, SLT and 111.
//  - Result truncated/wrapped to 32 bits regardless of overflow; no trapping.
//  - Adder and subtractor share one 33-bit adder (b inverted, carry-in 1 for sub).
//  - unsig has no effect on logic op results; affects only compout/overflow/SLT.
//  - op/unsig changes take effect on the next edge; no state beyond output registers.
// CONFIGURATION
//  ALU_SLT_EN defined: op 011 -> aluout={31'b0, compout} (signedness per unsig), overflow=0.
//  ALU_SLT_EN undefined: op 011 -> aluout=0, overflow=0; compout still valid.
// TESTING
//  - unsig=1 op=010 a=0x36B4F1A4 b=0x33EB7165 -> aluout=0x6AA06309, overflow=0, compout=0
//  - unsig=1 op=010 a=0x7FFFFFFF b=1 -> 0x80000000, overflow=1;
//    a=b=0xBFFFFFFF -> 0x7FFFFFFE, overflow=1
//  - unsig=0 op=010 a=0xFFFFFFFF b=1 -> 0, overflow=1;
//    a=0 b=0x7FFFFFFF -> 0x7FFFFFFF, overflow=0
//  - op=110 a=5 b=7 unsig=1 -> 0xFFFFFFFE, compout=1, overflow=0; unsig=0 -> overflow=1;
//    a=0x80000000 b=1: unsig=1 compout=1, unsig=0 compout=0
//  - a=0xF0F0F0F0 b=0xFF00FF00: op000 0xF000F000, 001 0xFFF0FFF0, 100 0x000F000F, 101 0x0FF00FF0
//  - rst pulsed mid-stream between edges -> all outputs 0 before next edge;
//    after release, first edge reflects current inputs

Source files
------------

// File: rtl/alu32.sv
// 32-bit registered ALU: logic ops, add/sub on one shared adder, a<b compare and overflow flags.
// Define ALU_SLT_EN to make op 011 return set-less-than; otherwise op 011 yields zero.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic [WIDTH-1:0] aluout,
  output logic             compout,
  output logic             overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  logic             sub_sel;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH:0]   sum;
  logic             less;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] aluout_next;
  logic             overflow_next;

  // One adder serves both add and sub: subtract is a + ~b + 1.
  assign sub_sel   = (op == OP_SUB);
  assign b_operand = sub_sel ? ~b : b;
  assign sum       = {1'b0, a} + {1'b0, b_operand} + {{WIDTH{1'b0}}, sub_sel};

  // unsig=1 selects signed interpretation.
  assign less = unsig ? ($signed(a) < $signed(b)) : (a < b);

  // Unsigned sub overflow is a borrow, i.e. no carry out of the inverted-b add.
  assign ovf_add = unsig ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                         : sum[WIDTH];
  assign ovf_sub = unsig ? ((a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                         : ~sum[WIDTH];

  always_comb begin
    aluout_next   = '0;
    overflow_next = 1'b0;
    case (op)
      OP_AND: aluout_next = a & b;
      OP_OR:  aluout_next = a | b;
      OP_ADD: begin
        aluout_next   = sum[WIDTH-1:0];
        overflow_next = ovf_add;
      end
      OP_SLT: begin
`ifdef ALU_SLT_EN
        aluout_next = {{(WIDTH-1){1'b0}}, less};
`else
        aluout_next = '0;
`endif
      end
      OP_NOR: aluout_next = ~(a | b);
      OP_XOR: aluout_next = a ^ b;
      OP_SUB: begin
        aluout_next   = sum[WIDTH-1:0];
        overflow_next = ovf_sub;
      end
      default: begin
        aluout_next   = '0;
        overflow_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluout   <= '0;
      compout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      aluout   <= aluout_next;
      compout  <= less;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: directed vectors plus random ops against a wide-integer model.
// Honours ALU_SLT_EN the same way the design does.
module tb_alu32;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    logic        ovf;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        unsig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        unsig = 1'b0;
  logic [31:0] aluout;
  logic        compout;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  alu32 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .unsig(unsig),
    .aluout(aluout), .compout(compout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: operands treated as mathematical integers in 64 bits.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [2:0] mop, input logic mus);
    exp_t e;
    longint ua, ub, sa, sb, s;
    logic [63:0] sbits;
    ua = longint'({32'b0, ma});
    ub = longint'({32'b0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    e.a = ma; e.b = mb; e.op = mop; e.unsig = mus;
    e.cmp = mus ? (sa < sb) : (ua < ub);
    e.ovf = 1'b0;
    e.res = '0;
    case (mop)
      3'b000: e.res = ma & mb;
      3'b001: e.res = ma | mb;
      3'b100: e.res = ~(ma | mb);
      3'b101: e.res = ma ^ mb;
      3'b010, 3'b110: begin
        if (mop == 3'b010) s = mus ? sa + sb : ua + ub;
        else               s = mus ? sa - sb : ua - ub;
        sbits = s;
        e.res = sbits[31:0];
        if (mus) e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        else     e.ovf = (s > 64'sd4294967295) || (s < 64'sd0);
      end
      3'b011: begin
`ifdef ALU_SLT_EN
        e.res = e.cmp ? 32'd1 : 32'd0;
`else
        e.res = 32'd0;
`endif
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                      input logic tus);
    @(negedge clk);
    a = ta; b = tb; op = top; unsig = tus;
    sb_q.push_back(model(ta, tb, top, tus));
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (aluout !== 32'd0 || compout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: got aluout=%h compout=%b overflow=%b, need all zero",
               name, aluout, compout, overflow);
    end
  endtask

  // Monitor: every edge with an outstanding transaction presents its result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (aluout !== e.res || compout !== e.cmp || overflow !== e.ovf) begin
          failures++;
          $display("FAIL op%b us=%b a=%h b=%h: got res=%h cmp=%b ovf=%b need res=%h cmp=%b ovf=%b",
                   e.op, e.unsig, e.a, e.b, aluout, compout, overflow, e.res, e.cmp, e.ovf);
        end else begin
          $display("ok   op%b us=%b a=%h b=%h res=%h cmp=%b ovf=%b",
                   e.op, e.unsig, e.a, e.b, aluout, compout, overflow);
        end
      end
    end
  end

  initial begin
    logic [31:0] corners [0:5];
    logic [31:0] ra, rb;
    int wait_cycles;
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h0000_0001; corners[5] = 32'hBFFF_FFFF;

    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    send(32'h36B4F1A4, 32'h33EB7165, 3'b010, 1'b1);
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b1);
    send(32'hBFFFFFFF, 32'hBFFFFFFF, 3'b010, 1'b1);
    send(32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0);
    send(32'h00000000, 32'h7FFFFFFF, 3'b010, 1'b0);
    send(32'd5, 32'd7, 3'b110, 1'b1);
    send(32'd5, 32'd7, 3'b110, 1'b0);
    send(32'h80000000, 32'h00000001, 3'b110, 1'b1);
    send(32'h80000000, 32'h00000001, 3'b110, 1'b0);
    send(32'h80000000, 32'h00000001, 3'b011, 1'b1);
    send(32'h80000000, 32'h00000001, 3'b011, 1'b0);
    send(32'h00000001, 32'h80000000, 3'b011, 1'b0);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b0);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 1'b1);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b0);
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 1'b1);
    send(32'h12345678, 32'h9ABCDEF0, 3'b111, 1'b1);

    // Mid-stream async reset, asserted and released between edges.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("async_reset_mid");
    #1 rst = 1'b0;
    send(32'h00000003, 32'h00000004, 3'b110, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      send(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results outstanding, need 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
